subtrator_serial_nbits: RTL and testbench
=========================================

Name: subtrator_serial_nbits

Overview:
- Parametrised, sequential successor to the team's 4-bit ripple-borrow subtractor.
- Computes A−B−Bin, or A+B+Bin in add mode, on WIDTH-bit operands, DIGIT bits per clock, with a start/done handshake.
- Serves as the arithmetic unit of the multi-cycle ULA datapath.
- Area scales with DIGIT; latency is WIDTH/DIGIT cycles.
- Also provides borrow/carry, signed overflow and zero flags.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥2.
- DIGIT, 1: bits processed per clock cycle. WIDTH must be an integer multiple of DIGIT; otherwise elaboration fails.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request new operation; sampled only in IDLE.
- modo  input  1  0 = subtract (A−B−Bin), 1 = add (A+B+Bin).
- A  input  WIDTH  minuend / addend.
- B  input  WIDTH  subtrahend / addend.
- Bin  input  1  borrow-in (subtract) or carry-in (add).
- S  output  WIDTH  result, registered.
- Bout  output  1  borrow-out (subtract) or carry-out (add).
- V  output  1  two's-complement overflow.
- Z  output  1  S == 0.
- busy  output  1  high while state is CALC.
- done  output  1  one-cycle pulse when S and flags are updated.

Behaviour:
Reset:
- rst_n low: state=IDLE and digit counter=0 immediately.
- S, Bout, V, Z, busy and done all go to 0 immediately.
- Reset mid-operation abandons the operation; no done pulse follows.

State IDLE:
- busy=0, done=0.
- start=1 at a rising edge:
  - latch A, B, Bin and modo into internal registers.
  - clear the partial result; counter=0; go to CALC.
- start=0: remain in IDLE.

State CALC:
- busy=1.
- Each edge processes digit k=counter, i.e. bits [k·DIGIT+DIGIT−1 : k·DIGIT].
- Uses the latched operands and the running borrow/carry register; the initial borrow/carry is the latched Bin.
- Writes the digit result into the partial result and updates borrow/carry; counter+1.
- Port A, B, Bin, modo and start changes have no effect.
- On the edge processing the last digit (counter = WIDTH/DIGIT−1):
  - S takes the full result; Bout, V and Z are updated.
  - go to DONE.

State DONE:
- done=1, busy=0 for exactly one cycle, then IDLE.
- start is ignored in DONE; a new operation is accepted only from IDLE.

Latency and throughput:
- Start sampled at edge t0: CALC occupies edges t0+1 … t0+N, where N=WIDTH/DIGIT.
- done is high in the cycle following edge t0+N.
- Back-to-back operations: minimum issue interval N+2 cycles.

Arithmetic:
- Subtract:
  - S = (A − B − Bin) mod 2^WIDTH.
  - Bout = 1 iff A < B + Bin, unsigned (same sense as the ripple subtractor).
  - V = (A[MSB] ≠ B[MSB]) and (S[MSB] ≠ A[MSB]).
- Add:
  - S = (A + B + Bin) mod 2^WIDTH.
  - Bout = carry out of the MSB.
  - V = (A[MSB] = B[MSB]) and (S[MSB] ≠ A[MSB]).
- Z = 1 iff S == 0.

Output holding:
- S, Bout, V and Z hold their values between operations.
- They change only on the final CALC edge or on reset.

Test Plan:
1. WIDTH=8, DIGIT=1, modo=0, A=0x05, B=0x03, Bin=0, start pulse → busy high 8 cycles; done one cycle later; S=0x02, Bout=0, V=0, Z=0.
2. WIDTH=8, DIGIT=1, modo=0, A=0x03, B=0x05, Bin=0 → S=0xFE, Bout=1. Then A=0x80, B=0x01, Bin=0 → S=0x7F, V=1, Bout=0. Then A=0x00, B=0x00, Bin=1 → S=0xFF, Bout=1.
3. WIDTH=8, DIGIT=4, modo=1, A=0xFF, B=0x01, Bin=0 → done 2 cycles after capture edge; S=0x00, Bout=1, Z=1, V=0. Then A=0x7F, B=0x01 → S=0x80, V=1.
4. WIDTH=4, DIGIT=4, modo=0, A=0x9, B=0x4, Bin=1 → single CALC cycle; S=0x4, Bout=0, V=1. Then sweep all 512 combinations of A, B, Bin against a reference model.
5. Start with A=0x05, B=0x03; change A, B and pulse start again during CALC and during DONE → result still S=0x02; only one done pulse; the second start is ignored.
6. Assert rst_n low at the 3rd CALC cycle of an 8-cycle operation → S/flags/busy/done=0 immediately; no done afterwards; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/subtrator_serial_nbits.sv
// Digit-serial adder/subtractor: A-B-Bin or A+B+Bin over WIDTH bits, DIGIT bits per clock.
// A start in IDLE latches the operands; S and the flags update on the final CALC edge, then done pulses.
module subtrator_serial_nbits #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             modo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] S,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int N   = WIDTH / DIGIT;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("subtrator_serial_nbits: WIDTH must be >= 2 and an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             modo_q, modo_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    int               lo;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   sum, diff, res;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        modo_d  = modo_q;
        cy_d    = cy_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;

        lo    = int'(cnt_q) * DIGIT;
        a_dig = a_q[lo +: DIGIT];
        b_dig = b_q[lo +: DIGIT];
        // One extra bit: its value is the carry out (add) or the borrow out (subtract, wraps negative).
        sum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cy_q};
        diff  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, cy_q};
        res   = modo_q ? sum : diff;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    modo_d  = modo;
                    cy_d    = Bin;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                part_d[lo +: DIGIT] = res[DIGIT-1:0];
                cy_d  = res[DIGIT];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    s_d    = part_d;
                    bout_d = res[DIGIT];
                    v_d    = modo_q ? ((a_q[MSB] == b_q[MSB]) && (part_d[MSB] != a_q[MSB]))
                                    : ((a_q[MSB] != b_q[MSB]) && (part_d[MSB] != a_q[MSB]));
                    z_d    = (part_d == '0);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            modo_q  <= 1'b0;
            cy_q    <= 1'b0;
            part_q  <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            modo_q  <= modo_d;
            cy_q    <= cy_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign Bout = bout_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_subtrator_serial_nbits.sv
// Bench for subtrator_serial_nbits: three configurations (8/1, 8/4, 4/4) share the clock and reset,
// expected results come from an integer reference model through a scoreboard queue.
module tb_subtrator_serial_nbits;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       modo, bin;
    logic [7:0] a, b;
    logic       start0, start1, start2;

    logic [7:0] s0, s1;
    logic [3:0] s2;
    logic       bout0, bout1, bout2, v0, v1, v2, z0, z1, z2;
    logic       busy0, busy1, busy2, done0, done1, done2;

    int         sel;
    int         n_pass   = 0;
    int         n_checks = 0;
    logic [10:0] exp_q[$];

    logic [7:0] cur_s;
    logic       cur_bout, cur_v, cur_z, cur_busy, cur_done;

    always #5 clk = ~clk;

    subtrator_serial_nbits #(.WIDTH(8), .DIGIT(1)) u_w8_d1 (
        .clk(clk), .rst_n(rst_n), .start(start0), .modo(modo), .A(a), .B(b), .Bin(bin),
        .S(s0), .Bout(bout0), .V(v0), .Z(z0), .busy(busy0), .done(done0)
    );

    subtrator_serial_nbits #(.WIDTH(8), .DIGIT(4)) u_w8_d4 (
        .clk(clk), .rst_n(rst_n), .start(start1), .modo(modo), .A(a), .B(b), .Bin(bin),
        .S(s1), .Bout(bout1), .V(v1), .Z(z1), .busy(busy1), .done(done1)
    );

    subtrator_serial_nbits #(.WIDTH(4), .DIGIT(4)) u_w4_d4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .modo(modo), .A(a[3:0]), .B(b[3:0]), .Bin(bin),
        .S(s2), .Bout(bout2), .V(v2), .Z(z2), .busy(busy2), .done(done2)
    );

    always_comb begin
        cur_s = s0; cur_bout = bout0; cur_v = v0; cur_z = z0; cur_busy = busy0; cur_done = done0;
        if (sel == 1) begin
            cur_s = s1; cur_bout = bout1; cur_v = v1; cur_z = z1; cur_busy = busy1; cur_done = done1;
        end else if (sel == 2) begin
            cur_s = {4'b0, s2}; cur_bout = bout2; cur_v = v2; cur_z = z2; cur_busy = busy2; cur_done = done2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {S[7:0], Bout, V, Z} computed with plain integers.
    function automatic logic [10:0] model(input int w, input bit m, input int av, input int bv, input int bi);
        int  mask, r, s;
        bit  bo, vv, am, bm, sm;
        mask = (1 << w) - 1;
        if (m) begin
            r  = av + bv + bi;
            bo = ((r >> w) & 1) != 0;
        end else begin
            r  = av - bv - bi;
            bo = av < (bv + bi);
        end
        s  = r & mask;
        am = ((av >> (w - 1)) & 1) != 0;
        bm = ((bv >> (w - 1)) & 1) != 0;
        sm = ((s  >> (w - 1)) & 1) != 0;
        vv = m ? (am == bm && sm != am) : (am != bm && sm != am);
        return {s[7:0], bo, vv, s == 0};
    endfunction

    task automatic drive_start(input int inst, input logic v);
        case (inst)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    // One full operation; with disturb set, inputs and start are scrambled through CALC and DONE.
    task automatic op(input int inst, input bit m, input logic [7:0] av, input logic [7:0] bv,
                      input bit bi, input bit disturb);
        int          w, n, k, busy_cnt, mask;
        logic [7:0]  prev_s;
        logic [10:0] got, e;
        w    = (inst == 2) ? 4 : 8;
        n    = (inst == 0) ? 8 : (inst == 1) ? 2 : 1;
        mask = (1 << w) - 1;
        sel  = inst;
        @(negedge clk);
        prev_s = cur_s;
        modo = m; a = av; b = bv; bin = bi;
        drive_start(inst, 1'b1);
        exp_q.push_back(model(w, m, int'(av) & mask, int'(bv) & mask, int'(bi)));
        @(posedge clk);
        k = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (disturb) begin
                a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
                modo = 1'($urandom_range(1)); bin = 1'($urandom_range(1));
                drive_start(inst, 1'b1);
            end else begin
                drive_start(inst, 1'b0);
            end
            if (!cur_done) begin
                if (cur_busy) busy_cnt++;
                check("hold_S_during_calc", cur_s, prev_s);
            end
        end while (!cur_done && k < 40);
        check("done_seen", cur_done, 1);
        check("done_latency", k, n + 1);
        check("busy_cycles", busy_cnt, n);
        check("busy_low_in_done", cur_busy, 0);
        got = {cur_s, cur_bout, cur_v, cur_z};
        e   = exp_q.pop_front();
        check("result_S_Bout_V_Z", got, e);
        @(negedge clk);
        drive_start(inst, 1'b0);
        check("done_single_pulse", cur_done, 0);
        @(negedge clk);
        check("idle_after_done", cur_busy, 0);
        check("hold_S_after_done", cur_s, e[10:3]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        rst_n = 1'b0; start0 = 0; start1 = 0; start2 = 0;
        modo = 0; bin = 0; a = '0; b = '0; sel = 0;
        repeat (2) @(negedge clk);
        check("reset_S", {s0, s1, 4'b0, s2}, 0);
        check("reset_flags", {bout0, v0, z0, bout1, v1, z1, bout2, v2, z2}, 0);
        check("reset_busy_done", {busy0, done0, busy1, done1, busy2, done2}, 0);
        rst_n = 1'b1;

        // 8-bit, 1 bit per clock, subtract
        op(0, 0, 8'h05, 8'h03, 0, 0);
        check("t1_S", cur_s, 8'h02);
        check("t1_flags", {cur_bout, cur_v, cur_z}, 3'b000);
        op(0, 0, 8'h03, 8'h05, 0, 0);
        check("t2a_S_Bout", {cur_s, cur_bout}, {8'hFE, 1'b1});
        op(0, 0, 8'h80, 8'h01, 0, 0);
        check("t2b_S_V_Bout", {cur_s, cur_v, cur_bout}, {8'h7F, 1'b1, 1'b0});
        op(0, 0, 8'h00, 8'h00, 1, 0);
        check("t2c_S_Bout", {cur_s, cur_bout}, {8'hFF, 1'b1});

        // Start ignored during CALC and DONE while inputs change
        op(0, 0, 8'h05, 8'h03, 0, 1);
        check("t5_S", cur_s, 8'h02);
        for (int i = 0; i < 6; i++)
            op(0, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)),
               1'($urandom_range(1)), 0);

        // Reset during the 3rd CALC cycle abandons the operation
        op(0, 0, 8'h05, 8'h03, 0, 0);
        sel = 0;
        @(negedge clk);
        a = 8'h40; b = 8'h11; modo = 0; bin = 0; start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_reset_S", s0, 8'h00);
        check("t6_reset_flags_busy_done", {bout0, v0, z0, busy0, done0}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done0 || busy0) saw_done = 1'b1;
        end
        check("t6_no_done_after_reset", saw_done, 0);
        op(0, 0, 8'h40, 8'h11, 0, 0);
        check("t6_fresh_S", cur_s, 8'h2F);

        // 8-bit, 4 bits per clock, add
        op(1, 1, 8'hFF, 8'h01, 0, 0);
        check("t3a_S_Bout_Z_V", {cur_s, cur_bout, cur_z, cur_v}, {8'h00, 1'b1, 1'b1, 1'b0});
        op(1, 1, 8'h7F, 8'h01, 0, 0);
        check("t3b_S_V", {cur_s, cur_v}, {8'h80, 1'b1});
        for (int i = 0; i < 8; i++)
            op(1, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)),
               1'($urandom_range(1)), 0);

        // 4-bit, single digit: directed case then exhaustive subtract sweep
        op(2, 0, 8'h09, 8'h04, 1, 0);
        check("t4_S_Bout_V", {cur_s, cur_bout, cur_v}, {8'h04, 1'b0, 1'b1});
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op(2, 0, 8'(ia), 8'(ib), 1'(ic), 0);
        for (int i = 0; i < 16; i++)
            op(2, 1, 8'($urandom_range(15)), 8'($urandom_range(15)), 1'($urandom_range(1)), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
